sensor_frame_packer: RTL
========================

# sensor_frame_packer

Upstream feeder of the cluster/calibration algorithm stage. It collects one frame of 16-bit sensor channel samples and packs them two per 32-bit word behind a 3-word header. It emits each frame as one Avalon-ST packet of N_CHANNELS/2+3 words (163 for 320 channels). Frames are buffered in a FIFO with commit/rollback, so the consumer only ever sees complete packets; incomplete or overflowing frames are dropped and counted.

## Interface
- N_CHANNELS, 320: samples per frame; must be even.
- FIFO_AW, 9: FIFO address width; depth is 2^FIFO_AW words.
- SYNC_WORD, 32'hAA55_F1B0: header word 0.

- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- frame_start  in  1  one-cycle pulse marking the start of a new frame (channel 0 follows)
- sample_valid  in  1  sample_data valid this cycle; no backpressure toward the sensor side
- sample_data  in  16  channel sample, channels in ascending order
- data_out_data  out  32  Avalon-ST source data
- data_out_valid  out  1  word valid
- data_out_ready  in  1  sink ready; readyLatency 0
- data_out_empty  out  2  constant 0
- data_out_startofpacket  out  1  asserted on header word 0
- data_out_endofpacket  out  1  asserted on the last data word
- frame_count  out  32  frames started since reset; wraps
- drop_count  out  16  frames dropped since reset; saturates at 16'hFFFF
- proto_err  out  1  sticky protocol-violation flag; cleared only by rst

## Operation
- Packet layout:
  - word0 = SYNC_WORD.
  - word1 = frame_count value at that frame's frame_start.
  - word2 = {drop_count at that frame's frame_start, N_CHANNELS[15:0]}.
  - word3+k = {sample[2k+1], sample[2k]}, for k = 0..N_CHANNELS/2-1.
- The FIFO is 34 bits wide: {sop, eop, data}. It keeps a speculative write pointer (spec_wr), a committed pointer (cmt_wr) and a read pointer (rd), each FIFO_AW+1 bits wide.
  - Full: spec_wr - rd == 2^FIFO_AW.
  - The reader sees words only up to cmt_wr.
- Writer FSM states: IDLE, HDR0, HDR1, HDR2, DATA.
  - IDLE: sample_valid is ignored. On frame_start → HDR0; frame_count increments in the frame_start cycle.
  - HDR0/HDR1/HDR2: each writes one header word, then advances (HDR2 → DATA).
  - DATA:
    - An even sample is latched into the low half.
    - An odd sample writes the word {odd, latched even} in its accepting cycle.
    - After the final data word is written: cmt_wr ← spec_wr+1 on the same edge, then → IDLE.
- Abort on FIFO full when a write is required:
  - spec_wr ← cmt_wr.
  - drop_count increments (saturating).
  - → IDLE; the rest of the frame is discarded.
- Early frame_start while in HDRx or DATA:
  - Rollback as for abort and increment drop_count.
  - The new frame begins: → HDR0, and frame_count increments.
- sample_valid in a frame_start cycle, in HDR0..HDR2, or in IDLE after a completed frame: the sample is discarded and proto_err is set.
- Reader:
  - One prefetch output register fed from the RAM (read latency 1).
  - data_out_valid is high while the register holds a word.
  - Pop on valid && ready; the register is refilled back-to-back when committed words remain.
- data_out_data, sop and eop are held stable while valid && !ready.

## Timing
- Reset: all outputs 0, all pointers 0, FSM IDLE, counters 0, proto_err 0.
- Reset asserted mid-frame or mid-packet: valid drops immediately (asynchronously). After release no fragment is emitted; the first packet out starts with sop.
- Header words are written on the 3 edges following the frame_start edge. The sensor guarantees no sample in that window; violations are handled as above.
- Latency: word0 of a committed frame appears on data_out_valid ≤ 2 cycles after commit when the reader is idle.
- Throughput: 1 word/cycle at ready=1.
- A simultaneous commit and pop in the same cycle must both take effect.
- A simultaneous abort and pop in the same cycle must both take effect.
- Pointer wrap is modulo 2^(FIFO_AW+1); there is no special case at the wrap point.

## Test plan
1. **Single frame, ready=1.** One frame with sample value = channel index.
   - Expect 163 words: word0 0xAA55F1B0 with sop, word1 0, word2 0x00000140, word3 0x00010000.
   - word162 0x013F013E with eop; empty=0 throughout.
2. **Backpressure.** 3 frames with ready toggled pseudo-randomly at ~50%.
   - Content identical to scenario 1, except word1 = 0, 1, 2 and word2 unchanged.
   - No data change while stalled.
3. **Overflow.** ready=0, FIFO_AW=9; send 4 frames.
   - Frames 1-3 (489 words) commit; frame 4 aborts; drop_count=1.
   - Release ready: exactly 3 packets.
   - A 5th frame then carries word1=4 and word2=0x00010140.
4. **Early frame_start.** frame_start arrives after 100 samples.
   - No partial packet; drop_count=1.
   - The next full frame's packet has word1=1 and word2=0x00010140.
5. **Guard-window violation.** sample_valid in the cycle after frame_start.
   - proto_err=1.
   - The packet uses the following samples as channels 0.., and remains 163 words.
6. **Reset during output.** rst asserted mid-packet.
   - Outputs go to 0 immediately.
   - After release, a new frame yields one clean packet starting with sop and word1=0.

Source files
------------

// File: rtl/sensor_frame_packer.sv
// Collects one frame of 16-bit channel samples, packs two per word behind a 3-word header,
// and streams whole frames out as Avalon-ST packets via a commit/rollback FIFO.
//
// state | meaning
// IDLE  | waiting for frame_start; samples ignored
// HDR0  | writing sync word
// HDR1  | writing frame_count snapshot
// HDR2  | writing {drop_count snapshot, N_CHANNELS}
// DATA  | pairing samples into data words; commit after the last pair
module sensor_frame_packer #(
   parameter int          N_CHANNELS = 320,
   parameter int          FIFO_AW    = 9,
   parameter logic [31:0] SYNC_WORD  = 32'hAA55_F1B0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        sample_valid,
   input  logic [15:0] sample_data,
   output logic [31:0] data_out_data,
   output logic        data_out_valid,
   input  logic        data_out_ready,
   output logic [1:0]  data_out_empty,
   output logic        data_out_startofpacket,
   output logic        data_out_endofpacket,
   output logic [31:0] frame_count,
   output logic [15:0] drop_count,
   output logic        proto_err
);

   localparam int PW    = FIFO_AW + 1;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = $clog2(N_CHANNELS / 2 + 1);

   localparam logic [PW-1:0] PONE      = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [PW-1:0] FULL_DIFF = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [CW-1:0] PAIRS_M1  = CW'(N_CHANNELS / 2 - 1);
   localparam logic [15:0]   NCH16     = 16'(N_CHANNELS);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR0 = 3'd1;
   localparam logic [2:0] S_HDR1 = 3'd2;
   localparam logic [2:0] S_HDR2 = 3'd3;
   localparam logic [2:0] S_DATA = 3'd4;

   logic [2:0]    state;
   logic [PW-1:0] spec_wr, cmt_wr, rd;
   logic [CW-1:0] pair_left;
   logic          odd_half;
   logic [15:0]   even_lat;
   logic [31:0]   hdr_fc;
   logic [15:0]   hdr_dc;
   logic          done_flag;
   logic [33:0]   out_word;
   logic          out_valid;
   logic [33:0]   mem [DEPTH];

   logic          in_frame, in_hdr, fifo_full, last_pair;
   logic          wr_req, wr_en, abort, drop_inc, bad_sample;
   logic          fetch;
   logic [15:0]   drop_next;
   logic [33:0]   wr_word;

   always_comb begin
      in_frame   = (state != S_IDLE);
      in_hdr     = (state == S_HDR0) || (state == S_HDR1) || (state == S_HDR2);
      fifo_full  = ((spec_wr - rd) == FULL_DIFF);
      last_pair  = (pair_left == '0);
      // frame_start has priority: nothing of the old frame is written in that cycle
      wr_req     = !frame_start &&
                   (in_hdr || ((state == S_DATA) && sample_valid && odd_half));
      wr_en      = wr_req && !fifo_full;
      abort      = wr_req && fifo_full;
      drop_inc   = abort || (frame_start && in_frame);
      drop_next  = (drop_inc && (drop_count != 16'hFFFF)) ? drop_count + 16'd1 : drop_count;
      bad_sample = sample_valid &&
                   (frame_start || in_hdr || ((state == S_IDLE) && done_flag));
   end

   always_comb begin
      wr_word = 34'd0;
      case (state)
         S_HDR0:  wr_word = {2'b10, SYNC_WORD};
         S_HDR1:  wr_word = {2'b00, hdr_fc};
         S_HDR2:  wr_word = {2'b00, hdr_dc, NCH16};
         S_DATA:  wr_word = {1'b0, last_pair, sample_data, even_lat};
         default: wr_word = 34'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         spec_wr     <= '0;
         cmt_wr      <= '0;
         pair_left   <= '0;
         odd_half    <= 1'b0;
         even_lat    <= 16'd0;
         hdr_fc      <= 32'd0;
         hdr_dc      <= 16'd0;
         done_flag   <= 1'b0;
         frame_count <= 32'd0;
         drop_count  <= 16'd0;
         proto_err   <= 1'b0;
      end else begin
         drop_count <= drop_next;
         if (bad_sample)
            proto_err <= 1'b1;
         if (frame_start) begin
            frame_count <= frame_count + 32'd1;
            hdr_fc      <= frame_count;
            hdr_dc      <= drop_next;
            pair_left   <= PAIRS_M1;
            odd_half    <= 1'b0;
            done_flag   <= 1'b0;
            if (in_frame)
               spec_wr <= cmt_wr;
            state <= S_HDR0;
         end else if (abort) begin
            spec_wr <= cmt_wr;
            state   <= S_IDLE;
         end else begin
            if (wr_en)
               spec_wr <= spec_wr + PONE;
            case (state)
               S_HDR0: state <= S_HDR1;
               S_HDR1: state <= S_HDR2;
               S_HDR2: state <= S_DATA;
               S_DATA: begin
                  if (sample_valid) begin
                     if (!odd_half) begin
                        even_lat <= sample_data;
                        odd_half <= 1'b1;
                     end else begin
                        odd_half <= 1'b0;
                        if (last_pair) begin
                           cmt_wr    <= spec_wr + PONE;
                           done_flag <= 1'b1;
                           state     <= S_IDLE;
                        end else begin
                           pair_left <= pair_left - 1'b1;
                        end
                     end
                  end
               end
               default: state <= state;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[spec_wr[FIFO_AW-1:0]] <= wr_word;
   end

   // Output register is the RAM read register; it only reloads when empty or being popped.
   assign fetch = (rd != cmt_wr) && (!out_valid || data_out_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd        <= '0;
         out_word  <= 34'd0;
         out_valid <= 1'b0;
      end else if (fetch) begin
         out_word  <= mem[rd[FIFO_AW-1:0]];
         rd        <= rd + PONE;
         out_valid <= 1'b1;
      end else if (out_valid && data_out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign data_out_data          = out_word[31:0];
   assign data_out_endofpacket   = out_word[32];
   assign data_out_startofpacket = out_word[33];
   assign data_out_valid         = out_valid;
   assign data_out_empty         = 2'b00;

endmodule
